instruction_fetch_unit: RTL

Fetch stage of the 20-bit pipelined processor. It drives the program counter, issues reads to the synchronous instruction memory, and presents `instruction`, `opcode` and `valid` to the IF/ID pipeline register. It supports downstream stall using a one-entry skid buffer, branch redirect with wrong-path squash, and a HALT opcode that stops fetching.

---
 rtl/instruction_fetch_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage of the 20-bit pipelined processor. Drives the PC, issues reads
// to a synchronous instruction memory (data returns one cycle after the
// strobe) and presents instruction/opcode/pc_out/valid to the IF/ID register.
// A one-entry skid buffer holds a word that arrives while downstream stalls,
// branch_taken redirects the PC and drops wrong-path data, and a HALT opcode
// stops fetching until reset.
//
// Handshake: an instruction is transferred to IF/ID in a cycle where
// valid = 1 and stall = 0. While stall = 1, the presented word is held
// (from the skid register once captured) and no new read is issued.
//
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   stall                 : downstream cannot accept this cycle
//   branch_taken          : one-cycle redirect request (ignored in HALT)
//   branch_target         : new PC when branch_taken is high
//   imem_data             : memory read data, valid the cycle after imem_rd_en
//   imem_addr, imem_rd_en : read address (PC register) and read strobe
//   instruction, opcode   : presented word and its [19:16] field
//   pc_out                : address of the presented word
//   valid                 : presented word is real (not a bubble)
//   halted                : registered HALT state indicator
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]            HALT_OPCODE = 4'b1111
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic [19:0]           imem_data,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_rd_en,
    output logic [19:0]           instruction,
    output logic [3:0]            opcode,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  valid,
    output logic                  halted
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] pending_pc_q, pending_pc_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [19:0]           skid_data_q, skid_data_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic                  squash_q, squash_d;

    logic                  running;
    logic                  present;
    logic                  consume;
    logic                  arrival;

    // Datapath / outputs
    always_comb begin
        running     = (state_q == ST_RUN);
        imem_addr   = pc_q;
        imem_rd_en  = running && !stall && !branch_taken && !reset;
        instruction = '0;
        pc_out      = '0;
        present     = 1'b0;
        arrival     = pending_q && !squash_q;

        if (skid_valid_q) begin
            instruction = skid_data_q;
            pc_out      = skid_pc_q;
            present     = 1'b1;
        end else if (arrival) begin
            instruction = imem_data;
            pc_out      = pending_pc_q;
            present     = 1'b1;
        end

        opcode  = instruction[19:16];
        // A read completing in a branch cycle is wrong-path, so the branch
        // cycle is always a bubble.
        valid   = present && running && !branch_taken && !reset;
        consume = valid && !stall;
        halted  = (state_q == ST_HALT);
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = imem_rd_en;
        pending_pc_d = imem_rd_en ? pc_q : pending_pc_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        squash_d     = squash_q;

        case (state_q)
            ST_RUN: begin
                if (consume && opcode == HALT_OPCODE) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (running && branch_taken) begin
            // Redirect wins over stall; anything buffered is wrong-path.
            pc_d         = branch_target;
            skid_valid_d = 1'b0;
            squash_d     = 1'b0;
        end else begin
            if (imem_rd_en) begin
                pc_d = pc_q + ADDR_WIDTH'(1);
            end
            if (consume) begin
                skid_valid_d = 1'b0;
            end else if (running && stall && arrival && !skid_valid_q) begin
                // Only one read is ever in flight, so one entry is enough.
                skid_valid_d = 1'b1;
                skid_data_d  = imem_data;
                skid_pc_d    = pending_pc_q;
            end
            // The read issued alongside the consumed HALT is past the end
            // of the program; mark it so it can never be presented.
            if (consume && opcode == HALT_OPCODE && imem_rd_en) begin
                squash_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
            squash_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            squash_q     <= squash_d;
        end
    end

endmodule
